// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-word type and constants for the pipeline control registers
package ctrl_pkg;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// rtl/ctrl_stage_reg.sv - one pipeline control-word register with synchronous bubble insertion
module ctrl_stage_reg
    import ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  ctrl_t d,
    output ctrl_t q
);

    // Capture the upstream word, or a bubble when this slot is being killed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= CTRL_BUBBLE;
        end else if (clr) begin
            q <= CTRL_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipe_regs.sv
// rtl/ctrl_pipe_regs.sv - ID/EX, EX/MEM, MEM/WB control registers with bubbles, PCSrc and counters
module ctrl_pipe_regs
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_d,
    input  logic             regwrite_d,
    input  logic             regdst_d,
    input  logic             alusrc_d,
    input  logic             branch_d,
    input  logic             memwrite_d,
    input  logic             memtoreg_d,
    input  logic [1:0]       aluop_d,
    input  logic             stall_d,
    input  logic             zero_m,
    output logic             regdst_e,
    output logic             alusrc_e,
    output logic [1:0]       aluop_e,
    output logic             regwrite_e,
    output logic             memtoreg_e,
    output logic             memwrite_m,
    output logic             regwrite_m,
    output logic             pcsrc_m,
    output logic             regwrite_w,
    output logic             memtoreg_w,
    output logic             valid_e,
    output logic             valid_w,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t decWord;
    ctrl_t idEx;
    ctrl_t exMem;
    ctrl_t memWb;
    logic  idExClr;
    logic  [1:0] squashInc;
    logic  [CNT_W+1:0] squashSum;

    // Pack the decoder fields into one control word
    always_comb begin
        decWord          = CTRL_BUBBLE;
        decWord.valid    = valid_d;
        decWord.regwrite = regwrite_d;
        decWord.regdst   = regdst_d;
        decWord.alusrc   = alusrc_d;
        decWord.branch   = branch_d;
        decWord.memwrite = memwrite_d;
        decWord.memtoreg = memtoreg_d;
        decWord.aluop    = aluop_d;
    end

    // A taken branch kills ID and EX; a stall or an empty ID slot only bubbles EX
    assign pcsrc_m = exMem.branch & zero_m;
    assign idExClr = pcsrc_m | stall_d | ~valid_d;

    ctrl_stage_reg u_id_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (idExClr),
        .d     (decWord),
        .q     (idEx)
    );

    ctrl_stage_reg u_ex_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pcsrc_m),
        .d     (idEx),
        .q     (exMem)
    );

    ctrl_stage_reg u_mem_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .d     (exMem),
        .q     (memWb)
    );

    assign regdst_e   = idEx.regdst;
    assign alusrc_e   = idEx.alusrc;
    assign aluop_e    = idEx.aluop;
    assign regwrite_e = idEx.regwrite;
    assign memtoreg_e = idEx.memtoreg;
    assign valid_e    = idEx.valid;
    assign memwrite_m = exMem.memwrite;
    assign regwrite_m = exMem.regwrite;
    assign regwrite_w = memWb.regwrite;
    assign memtoreg_w = memWb.memtoreg;
    assign valid_w    = memWb.valid;

    // The ID slot is counted once even when stall and flush coincide
    assign squashInc = {1'b0, valid_d & (stall_d | pcsrc_m)} + {1'b0, valid_e & pcsrc_m};
    assign squashSum = {2'b00, squash_cnt} + {{CNT_W{1'b0}}, squashInc};

    // Saturating counters of retired and squashed instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            squash_cnt  <= '0;
        end else begin
            if (valid_w && (retired_cnt != CNT_MAX)) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
            if (squashSum > {2'b00, CNT_MAX}) begin
                squash_cnt <= CNT_MAX;
            end else begin
                squash_cnt <= squashSum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// tb/tb_ctrl_pipe_regs.sv - self-checking bench for ctrl_pipe_regs against a pipeline-slot model
module tb_ctrl_pipe_regs;
    import ctrl_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    localparam logic [7:0] W_RTYPE = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
    localparam logic [7:0] W_LW    = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ALUOP_ADD};
    localparam logic [7:0] W_BEQ   = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_SUB};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_d = 1'b0;
    logic          regwrite_d = 1'b0;
    logic          regdst_d = 1'b0;
    logic          alusrc_d = 1'b0;
    logic          branch_d = 1'b0;
    logic          memwrite_d = 1'b0;
    logic          memtoreg_d = 1'b0;
    logic [1:0]    aluop_d = 2'b00;
    logic          stall_d = 1'b0;
    logic          zero_m = 1'b0;
    logic          regdst_e;
    logic          alusrc_e;
    logic [1:0]    aluop_e;
    logic          regwrite_e;
    logic          memtoreg_e;
    logic          memwrite_m;
    logic          regwrite_m;
    logic          pcsrc_m;
    logic          regwrite_w;
    logic          memtoreg_w;
    logic          valid_e;
    logic          valid_w;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] squash_cnt;

    int numChecks = 0;
    int numFails  = 0;

    // Model: slot 0 = EX, 1 = MEM, 2 = WB; bits {valid, regwrite, regdst, alusrc, branch, memwrite, memtoreg, aluop}
    logic [8:0] slot [3];
    int         mRet;
    int         mSq;
    logic       lastPcsrc;

    ctrl_pipe_regs #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_d     (valid_d),
        .regwrite_d  (regwrite_d),
        .regdst_d    (regdst_d),
        .alusrc_d    (alusrc_d),
        .branch_d    (branch_d),
        .memwrite_d  (memwrite_d),
        .memtoreg_d  (memtoreg_d),
        .aluop_d     (aluop_d),
        .stall_d     (stall_d),
        .zero_m      (zero_m),
        .regdst_e    (regdst_e),
        .alusrc_e    (alusrc_e),
        .aluop_e     (aluop_e),
        .regwrite_e  (regwrite_e),
        .memtoreg_e  (memtoreg_e),
        .memwrite_m  (memwrite_m),
        .regwrite_m  (regwrite_m),
        .pcsrc_m     (pcsrc_m),
        .regwrite_w  (regwrite_w),
        .memtoreg_w  (memtoreg_w),
        .valid_e     (valid_e),
        .valid_w     (valid_w),
        .retired_cnt (retired_cnt),
        .squash_cnt  (squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int satAdd(input int a, input int b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    task automatic checkAll();
        checkVal("regdst_e",    32'(regdst_e),    32'(slot[0][6]));
        checkVal("alusrc_e",    32'(alusrc_e),    32'(slot[0][5]));
        checkVal("aluop_e",     32'(aluop_e),     32'(slot[0][1:0]));
        checkVal("regwrite_e",  32'(regwrite_e),  32'(slot[0][7]));
        checkVal("memtoreg_e",  32'(memtoreg_e),  32'(slot[0][2]));
        checkVal("valid_e",     32'(valid_e),     32'(slot[0][8]));
        checkVal("memwrite_m",  32'(memwrite_m),  32'(slot[1][3]));
        checkVal("regwrite_m",  32'(regwrite_m),  32'(slot[1][7]));
        checkVal("pcsrc_m",     32'(pcsrc_m),     32'(slot[1][4] & zero_m));
        checkVal("regwrite_w",  32'(regwrite_w),  32'(slot[2][7]));
        checkVal("memtoreg_w",  32'(memtoreg_w),  32'(slot[2][2]));
        checkVal("valid_w",     32'(valid_w),     32'(slot[2][8]));
        checkVal("retired_cnt", 32'(retired_cnt), 32'(mRet));
        checkVal("squash_cnt",  32'(squash_cnt),  32'(mSq));
    endtask

    task automatic checkZero();
        zero_m = 1'b1;
        #1;
        checkVal("rst_regdst_e",    32'(regdst_e),    0);
        checkVal("rst_alusrc_e",    32'(alusrc_e),    0);
        checkVal("rst_aluop_e",     32'(aluop_e),     0);
        checkVal("rst_regwrite_e",  32'(regwrite_e),  0);
        checkVal("rst_memtoreg_e",  32'(memtoreg_e),  0);
        checkVal("rst_memwrite_m",  32'(memwrite_m),  0);
        checkVal("rst_regwrite_m",  32'(regwrite_m),  0);
        checkVal("rst_pcsrc_m",     32'(pcsrc_m),     0);
        checkVal("rst_regwrite_w",  32'(regwrite_w),  0);
        checkVal("rst_memtoreg_w",  32'(memtoreg_w),  0);
        checkVal("rst_valid_e",     32'(valid_e),     0);
        checkVal("rst_valid_w",     32'(valid_w),     0);
        checkVal("rst_retired_cnt", 32'(retired_cnt), 0);
        checkVal("rst_squash_cnt",  32'(squash_cnt),  0);
    endtask

    // One instruction slot per cycle: kill rules applied to the in-flight words, then everything advances
    task automatic modelEdge(input logic [7:0] f);
        logic taken;
        int   killed;
        taken  = slot[1][4] & zero_m;
        killed = 0;
        if (valid_d && (stall_d || taken)) killed++;
        if (slot[0][8] && taken) killed++;
        mSq = satAdd(mSq, killed);
        if (slot[2][8]) mRet = satAdd(mRet, 1);
        slot[2] = slot[1];
        slot[1] = taken ? 9'd0 : slot[0];
        slot[0] = (taken || stall_d || !valid_d) ? 9'd0 : {1'b1, f};
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one
    task automatic cycle(input logic vd, input logic [7:0] f, input logic st, input logic zm);
        valid_d = vd;
        {regwrite_d, regdst_d, alusrc_d, branch_d, memwrite_d, memtoreg_d, aluop_d} = f;
        stall_d = st;
        zero_m  = zm;
        #2;
        lastPcsrc = pcsrc_m;
        checkAll();
        modelEdge(f);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases after the next edge
    task automatic resetMid();
        #2;
        rst_n = 1'b0;
        checkZero();
        for (int i = 0; i < 3; i++) slot[i] = 9'd0;
        mRet = 0;
        mSq  = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) slot[i] = 9'd0;
        mRet = 0;
        mSq  = 0;
        @(posedge clk);
        #1;
        resetMid();

        // R-type flows through every stage and retires
        cycle(1'b1, W_RTYPE, 1'b0, 1'b0);
        checkVal("t1_regdst_e", 32'(regdst_e), 1);
        checkVal("t1_aluop_e",  32'(aluop_e),  2);
        checkVal("t1_alusrc_e", 32'(alusrc_e), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checkVal("t1_regwrite_m", 32'(regwrite_m), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checkVal("t1_regwrite_w", 32'(regwrite_w), 1);
        checkVal("t1_valid_w",    32'(valid_w),    1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checkVal("t1_retired", 32'(retired_cnt), 1);

        // lw followed by a one-cycle stall
        resetMid();
        cycle(1'b1, W_LW, 1'b0, 1'b0);
        checkVal("t2_memtoreg_e", 32'(memtoreg_e), 1);
        cycle(1'b1, W_RTYPE, 1'b1, 1'b0);
        checkVal("t2_bubble_e", 32'(valid_e),    0);
        checkVal("t2_squash",   32'(squash_cnt), 1);
        cycle(1'b1, W_RTYPE, 1'b0, 1'b0);
        checkVal("t2_valid_e",    32'(valid_e),    1);
        checkVal("t2_memtoreg_w", 32'(memtoreg_w), 1);

        // taken beq flushes EX and ID
        resetMid();
        cycle(1'b1, W_BEQ,   1'b0, 1'b0);
        cycle(1'b1, W_RTYPE, 1'b0, 1'b0);
        cycle(1'b1, W_RTYPE, 1'b0, 1'b1);
        checkVal("t3_pcsrc",      32'(lastPcsrc),  1);
        checkVal("t3_valid_e",    32'(valid_e),    0);
        checkVal("t3_regwrite_m", 32'(regwrite_m), 0);
        checkVal("t3_squash",     32'(squash_cnt), 2);
        checkVal("t3_valid_w",    32'(valid_w),    1);
        checkVal("t3_regwrite_w", 32'(regwrite_w), 0);

        // not-taken beq: nothing squashed, all three retire
        resetMid();
        cycle(1'b1, W_BEQ,   1'b0, 1'b0);
        cycle(1'b1, W_RTYPE, 1'b0, 1'b0);
        cycle(1'b1, W_LW,    1'b0, 1'b0);
        checkVal("t4_pcsrc", 32'(lastPcsrc), 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checkVal("t4_retired", 32'(retired_cnt), 3);
        checkVal("t4_squash",  32'(squash_cnt),  0);

        // stall and flush together count the ID slot once
        resetMid();
        cycle(1'b1, W_BEQ,   1'b0, 1'b0);
        cycle(1'b1, W_RTYPE, 1'b0, 1'b0);
        cycle(1'b1, W_RTYPE, 1'b1, 1'b1);
        checkVal("t5_squash",  32'(squash_cnt), 2);
        checkVal("t5_valid_e", 32'(valid_e),    0);

        // saturation of the retired counter, then reset with words in flight
        resetMid();
        for (int i = 0; i < 20; i++) cycle(1'b1, W_RTYPE, 1'b0, 1'b0);
        checkVal("t6_retired_sat", 32'(retired_cnt), CMAX);
        resetMid();

        // randomized traffic with periodic mid-stream resets
        for (int n = 0; n < 400; n++) begin
            if (n % 60 == 59) begin
                resetMid();
            end else begin
                cycle($urandom_range(0, 3) != 0, 8'($urandom),
                      $urandom_range(0, 4) == 0, 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
